// File: rtl/mprj_pad_config_sequencer.sv
// Pad configuration sequencer.
// Stores one configuration word per user-project pad. On request it shifts every
// word MSB-first down the pad daisy chain on a divided serial clock. It then pulses
// a load strobe so that all pad control blocks latch their words in the same cycle.
module mprj_pad_config_sequencer #(
   parameter int               N_PADS      = 38,
   parameter int               CFG_W       = 13,
   parameter int               AW          = 6,
   parameter int               DIV_W       = 8,
   parameter logic [CFG_W-1:0] DEFAULT_CFG = 13'h0403
) (
   input  logic             clock_core,
   input  logic             rstb,
   input  logic             cfg_wr_en,
   input  logic [AW-1:0]    cfg_wr_addr,
   input  logic [CFG_W-1:0] cfg_wr_data,
   output logic             cfg_wr_nack,
   input  logic [AW-1:0]    cfg_rd_addr,
   output logic [CFG_W-1:0] cfg_rd_data,
   input  logic [DIV_W-1:0] clk_div,
   input  logic             xfer_start,
   input  logic             xfer_abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             serial_clock,
   output logic             serial_data,
   output logic             serial_load
);

   localparam int            BW       = (CFG_W > 1) ? $clog2(CFG_W) : 1;
   localparam logic [AW-1:0] PAD_LAST = AW'(N_PADS - 1);
   localparam logic [BW-1:0] BIT_MSB  = BW'(CFG_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD} state_t;

   logic [CFG_W-1:0] cfg_mem [N_PADS];

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [AW-1:0]    pad_q, pad_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             busy_d, done_d, aborted_d, sclk_d, sdata_d, sload_d;

   // Pre-write copy of a word written in the same cycle a transfer starts.
   logic             shadow_valid;
   logic [AW-1:0]    shadow_addr;
   logic [CFG_W-1:0] shadow_word;

   logic             wr_ok;
   logic             phase_end;
   logic             last_bit;
   logic [AW-1:0]    nxt_pad;
   logic [BW-1:0]    nxt_bit;
   logic [CFG_W-1:0] nxt_word;

   assign wr_ok     = cfg_wr_en && !busy && (int'(cfg_wr_addr) < N_PADS);
   assign phase_end = (cnt_q == div_q);
   assign last_bit  = (pad_q == '0) && (bit_q == '0);
   assign nxt_pad   = (bit_q == '0) ? pad_q - 1'b1 : pad_q;
   assign nxt_bit   = (bit_q == '0) ? BIT_MSB : bit_q - 1'b1;
   assign nxt_word  = (shadow_valid && (shadow_addr == nxt_pad)) ? shadow_word : cfg_mem[nxt_pad];

   assign cfg_rd_data = (int'(cfg_rd_addr) < N_PADS) ? cfg_mem[cfg_rd_addr] : '0;

   // Config word storage and the write-drop indication.
   always_ff @(posedge clock_core or negedge rstb) begin
      if (!rstb) begin
         // NOTE: the words must come back as DEFAULT_CFG on every reset, so this is a reset flop array, not a RAM.
         for (int i = 0; i < N_PADS; i++) cfg_mem[i] <= DEFAULT_CFG;
         cfg_wr_nack <= 1'b0;
      end else begin
         if (wr_ok) cfg_mem[cfg_wr_addr] <= cfg_wr_data;
         cfg_wr_nack <= cfg_wr_en && !wr_ok;
      end
   end

   // Capture the old value of a word overwritten on the start cycle so the chain still sees it.
   always_ff @(posedge clock_core or negedge rstb) begin
      if (!rstb) begin
         shadow_valid <= 1'b0;
         shadow_addr  <= '0;
         shadow_word  <= '0;
      end else if (state_q == IDLE && xfer_start) begin
         shadow_valid <= wr_ok;
         shadow_addr  <= cfg_wr_addr;
         if (wr_ok) shadow_word <= cfg_mem[cfg_wr_addr];
      end
   end

   // FSM state, phase counter, bit pointer and registered chain outputs.
   always_ff @(posedge clock_core or negedge rstb) begin
      if (!rstb) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         div_q        <= '0;
         pad_q        <= '0;
         bit_q        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         serial_clock <= 1'b0;
         serial_data  <= 1'b0;
         serial_load  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values, independent of statement order.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         pad_q        <= pad_d;
         bit_q        <= bit_d;
         busy         <= busy_d;
         done         <= done_d;
         aborted      <= aborted_d;
         serial_clock <= sclk_d;
         serial_data  <= sdata_d;
         serial_load  <= sload_d;
      end
   end

   // Next-state logic: each phase lasts div_q+1 cycles; abort overrides everything while busy.
   always_comb begin
      // NOTE: every target gets a default first so no path through the case infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      pad_d     = pad_q;
      bit_d     = bit_q;
      busy_d    = busy;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      sclk_d    = serial_clock;
      sdata_d   = serial_data;
      sload_d   = serial_load;

      case (state_q)
         IDLE: begin
            if (xfer_start) begin
               state_d = SHIFT_LO;
               cnt_d   = '0;
               div_d   = clk_div;
               pad_d   = PAD_LAST;
               bit_d   = BIT_MSB;
               busy_d  = 1'b1;
               sclk_d  = 1'b0;
               sload_d = 1'b0;
               sdata_d = cfg_mem[PAD_LAST][CFG_W-1];
            end
         end
         SHIFT_LO: begin
            cnt_d = cnt_q + 1'b1;
            if (phase_end) begin
               state_d = SHIFT_HI;
               cnt_d   = '0;
               sclk_d  = 1'b1;
            end
         end
         SHIFT_HI: begin
            cnt_d = cnt_q + 1'b1;
            if (phase_end) begin
               cnt_d  = '0;
               sclk_d = 1'b0;
               if (last_bit) begin
                  state_d = LOAD;
                  sload_d = 1'b1;
                  sdata_d = 1'b0;
               end else begin
                  state_d = SHIFT_LO;
                  pad_d   = nxt_pad;
                  bit_d   = nxt_bit;
                  sdata_d = nxt_word[nxt_bit];
               end
            end
         end
         LOAD: begin
            cnt_d = cnt_q + 1'b1;
            if (phase_end) begin
               state_d = IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sload_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && xfer_abort) begin
         state_d   = IDLE;
         cnt_d     = '0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         aborted_d = 1'b1;
         sclk_d    = 1'b0;
         sdata_d   = 1'b0;
         sload_d   = 1'b0;
      end
   end

endmodule

// File: tb/tb_mprj_pad_config_sequencer.sv
// Testbench for mprj_pad_config_sequencer.
// A cycle-level reference model derives every output from the transfer start time
// and a snapshot of the config words. Directed tests add literal expectations.
module tb_mprj_pad_config_sequencer;

   localparam int               N_PADS = 38;
   localparam int               CFG_W  = 13;
   localparam int               AW     = 6;
   localparam int               DIV_W  = 8;
   localparam int               NB     = N_PADS * CFG_W;
   localparam logic [CFG_W-1:0] DEF    = 13'h0403;

   logic             clk = 1'b0;
   logic             rstb;
   logic             cfg_wr_en;
   logic [AW-1:0]    cfg_wr_addr;
   logic [CFG_W-1:0] cfg_wr_data;
   logic             cfg_wr_nack;
   logic [AW-1:0]    cfg_rd_addr;
   logic [CFG_W-1:0] cfg_rd_data;
   logic [DIV_W-1:0] clk_div;
   logic             xfer_start;
   logic             xfer_abort;
   logic             busy;
   logic             done;
   logic             aborted;
   logic             serial_clock;
   logic             serial_data;
   logic             serial_load;

   mprj_pad_config_sequencer dut (
      .clock_core   (clk),
      .rstb         (rstb),
      .cfg_wr_en    (cfg_wr_en),
      .cfg_wr_addr  (cfg_wr_addr),
      .cfg_wr_data  (cfg_wr_data),
      .cfg_wr_nack  (cfg_wr_nack),
      .cfg_rd_addr  (cfg_rd_addr),
      .cfg_rd_data  (cfg_rd_data),
      .clk_div      (clk_div),
      .xfer_start   (xfer_start),
      .xfer_abort   (xfer_abort),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .serial_clock (serial_clock),
      .serial_data  (serial_data),
      .serial_load  (serial_load)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state.
   logic [CFG_W-1:0] m_mem [N_PADS];
   bit               m_bits [NB];
   bit               m_busy, m_was_busy, e_done, e_abort, e_nack;
   int               m_start, m_h, ecount;

   // Observed-behaviour records.
   int done_total, load_total, abort_total;
   int busy_run, hi_run, lo_run;
   bit bits_q [$];
   int hi_q [$];
   int lo_q [$];
   int busy_q [$];
   logic prev_sclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [CFG_W-1:0] get_word(input int base);
      logic [CFG_W-1:0] w = '0;
      for (int i = 0; i < CFG_W; i++)
         if (base + i < bits_q.size()) w = {w[CFG_W-2:0], bits_q[base+i]};
      return w;
   endfunction

   // Model: a transfer is a start edge, a half-period H and a bit snapshot.
   task automatic model_loop();
      forever begin
         @(posedge clk or negedge rstb);
         if (!rstb) begin
            for (int i = 0; i < N_PADS; i++) m_mem[i] = DEF;
            m_busy = 1'b0; e_done = 1'b0; e_abort = 1'b0; e_nack = 1'b0;
         end else begin
            ecount++;
            m_was_busy = m_busy;
            e_done  = 1'b0;
            e_abort = 1'b0;
            e_nack  = cfg_wr_en && (m_was_busy || int'(cfg_wr_addr) >= N_PADS);
            if (m_was_busy) begin
               if (xfer_abort) begin
                  m_busy = 1'b0; e_abort = 1'b1;
               end else if (ecount - m_start == (2 * NB + 1) * m_h) begin
                  m_busy = 1'b0; e_done = 1'b1;
               end
            end else if (xfer_start) begin
               for (int j = 0; j < NB; j++)
                  m_bits[j] = m_mem[N_PADS - 1 - j / CFG_W][CFG_W - 1 - j % CFG_W];
               m_busy  = 1'b1;
               m_start = ecount;
               m_h     = int'(clk_div) + 1;
            end
            if (cfg_wr_en && !m_was_busy && int'(cfg_wr_addr) < N_PADS)
               m_mem[cfg_wr_addr] = cfg_wr_data;
         end
      end
   endtask

   // Per-cycle compare against the model, then record observed chain activity.
   task automatic cmp_loop();
      int   k, ph;
      logic e_sclk, e_sdata, e_sload;
      logic [CFG_W-1:0] e_rd;
      forever begin
         @(negedge clk);
         if (rstb === 1'b1) begin
            e_sclk = 1'b0; e_sdata = 1'b0; e_sload = 1'b0;
            if (m_busy) begin
               k  = ecount - m_start;
               ph = k / m_h;
               if (ph < 2 * NB) begin
                  e_sclk  = (ph % 2 == 1);
                  e_sdata = m_bits[ph / 2];
               end else begin
                  e_sload = 1'b1;
               end
            end
            e_rd = (int'(cfg_rd_addr) < N_PADS) ? m_mem[cfg_rd_addr] : '0;
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, e_done);
            check("cyc_aborted", aborted, e_abort);
            check("cyc_nack", cfg_wr_nack, e_nack);
            check("cyc_sclk", serial_clock, e_sclk);
            check("cyc_sdata", serial_data, e_sdata);
            check("cyc_sload", serial_load, e_sload);
            check("cyc_rd_data", cfg_rd_data, e_rd);
         end
         if (done === 1'b1) done_total++;
         if (serial_load === 1'b1) load_total++;
         if (aborted === 1'b1) abort_total++;
         if (serial_clock === 1'b1 && prev_sclk !== 1'b1) bits_q.push_back(serial_data);
         prev_sclk = serial_clock;
         if (serial_clock === 1'b1) hi_run++;
         else if (hi_run > 0) begin hi_q.push_back(hi_run); hi_run = 0; end
         if (busy === 1'b1 && serial_clock === 1'b0 && serial_load === 1'b0) lo_run++;
         else if (lo_run > 0) begin lo_q.push_back(lo_run); lo_run = 0; end
         if (busy === 1'b1) busy_run++;
         else if (busy_run > 0) begin busy_q.push_back(busy_run); busy_run = 0; end
      end
   endtask

   task automatic start_xfer(input logic [DIV_W-1:0] div);
      clk_div    = div;
      xfer_start = 1'b1;
      tick(1);
      xfer_start = 1'b0;
   endtask

   task automatic write_cfg(input int addr, input logic [CFG_W-1:0] data);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = AW'(addr);
      cfg_wr_data = data;
      tick(1);
      cfg_wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy === 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
      check("wait_idle_timeout", busy, 1'b0);
      tick(2);
   endtask

   function automatic int last_busy_len();
      return (busy_q.size() > 0) ? busy_q[$] : -1;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, d0, l0, a0, hb, lb, hmin, hmax, lmin, lmax;
      rstb = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
      cfg_rd_addr = '0; clk_div = '0; xfer_start = 1'b0; xfer_abort = 1'b0;
      fork
         model_loop();
         cmp_loop();
      join_none
      repeat (3) @(posedge clk);
      #1 rstb = 1'b1;

      // Reset state and default words.
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_aborted", aborted, 1'b0);
      check("rst_nack", cfg_wr_nack, 1'b0);
      check("rst_sclk", serial_clock, 1'b0);
      check("rst_sdata", serial_data, 1'b0);
      check("rst_sload", serial_load, 1'b0);
      for (int a = 0; a < N_PADS; a++) begin
         cfg_rd_addr = AW'(a);
         #1 check($sformatf("rst_rd[%0d]", a), cfg_rd_data, 13'h0403);
      end
      cfg_rd_addr = 6'd38;
      #1 check("rd_oor_38", cfg_rd_data, 13'h0000);
      cfg_rd_addr = 6'd63;
      #1 check("rd_oor_63", cfg_rd_data, 13'h0000);
      tick(1);

      // Full transfer at D=0.
      write_cfg(37, 13'h1FFF);
      write_cfg(0, 13'h0001);
      base = bits_q.size(); d0 = done_total; l0 = load_total;
      start_xfer(8'd0);
      wait_idle(2000);
      check("d0_first13", get_word(base), 13'h1FFF);
      check("d0_last13", get_word(base + NB - CFG_W), 13'h0001);
      check("d0_bit_count", bits_q.size() - base, 494);
      check("d0_busy_len", last_busy_len(), 989);
      check("d0_done_count", done_total - d0, 1);
      check("d0_load_cycles", load_total - l0, 1);

      // D=3, with clk_div changed mid-transfer.
      hb = hi_q.size(); lb = lo_q.size();
      start_xfer(8'd3);
      tick(100);
      clk_div = 8'd9;
      wait_idle(5000);
      clk_div = 8'd0;
      check("d3_busy_len", last_busy_len(), 3956);
      check("d3_hi_count", hi_q.size() - hb, 494);
      check("d3_lo_count", lo_q.size() - lb, 494);
      hmin = 1000; hmax = 0; lmin = 1000; lmax = 0;
      for (int i = hb; i < hi_q.size(); i++) begin
         if (hi_q[i] < hmin) hmin = hi_q[i];
         if (hi_q[i] > hmax) hmax = hi_q[i];
      end
      for (int i = lb; i < lo_q.size(); i++) begin
         if (lo_q[i] < lmin) lmin = lo_q[i];
         if (lo_q[i] > lmax) lmax = lo_q[i];
      end
      check("d3_hi_min", hmin, 4);
      check("d3_hi_max", hmax, 4);
      check("d3_lo_min", lmin, 4);
      check("d3_lo_max", lmax, 4);

      // Write and second start while busy are dropped/ignored.
      d0 = done_total; l0 = load_total;
      start_xfer(8'd0);
      tick(9);
      write_cfg(5, 13'h0AAA);
      check("busy_wr_nack", cfg_wr_nack, 1'b1);
      cfg_rd_addr = 6'd5;
      #1 check("busy_wr_unchanged", cfg_rd_data, 13'h0403);
      xfer_start = 1'b1;
      tick(1);
      xfer_start = 1'b0;
      wait_idle(2000);
      check("restart_done_count", done_total - d0, 1);
      check("restart_load_cycles", load_total - l0, 1);
      check("restart_busy_len", last_busy_len(), 989);
      write_cfg(40, 13'h0123);
      check("oor_wr_nack", cfg_wr_nack, 1'b1);
      write_cfg(6, 13'h0155);
      check("ok_wr_no_nack", cfg_wr_nack, 1'b0);
      cfg_rd_addr = 6'd6;
      #1 check("ok_wr_readback", cfg_rd_data, 13'h0155);
      tick(1);

      // Abort in IDLE is ignored.
      xfer_abort = 1'b1;
      tick(1);
      xfer_abort = 1'b0;
      check("idle_abort_pulse", aborted, 1'b0);
      check("idle_abort_busy", busy, 1'b0);

      // Abort at bit 100, then a clean transfer.
      base = bits_q.size(); d0 = done_total; l0 = load_total; a0 = abort_total;
      start_xfer(8'd0);
      tick(200);
      xfer_abort = 1'b1;
      tick(1);
      xfer_abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_pulse", aborted, 1'b1);
      check("abort_sclk", serial_clock, 1'b0);
      check("abort_sload", serial_load, 1'b0);
      check("abort_sdata", serial_data, 1'b0);
      tick(2);
      check("abort_no_done", done_total - d0, 0);
      check("abort_no_load", load_total - l0, 0);
      check("abort_count", abort_total - a0, 1);
      check("abort_bits", bits_q.size() - base, 100);
      d0 = done_total;
      start_xfer(8'd0);
      wait_idle(2000);
      check("post_abort_busy_len", last_busy_len(), 989);
      check("post_abort_done", done_total - d0, 1);

      // Write and start together: the chain carries the pre-write word.
      base = bits_q.size();
      cfg_wr_en = 1'b1; cfg_wr_addr = 6'd37; cfg_wr_data = 13'h0000;
      clk_div = 8'd0; xfer_start = 1'b1;
      tick(1);
      cfg_wr_en = 1'b0; xfer_start = 1'b0;
      check("simul_busy", busy, 1'b1);
      check("simul_no_nack", cfg_wr_nack, 1'b0);
      cfg_rd_addr = 6'd37;
      #1 check("simul_wr_taken", cfg_rd_data, 13'h0000);
      wait_idle(2000);
      check("simul_pre_write_word", get_word(base), 13'h1FFF);
      check("simul_pad36_word", get_word(base + CFG_W), 13'h0403);

      // Abort and start together in IDLE: start wins.
      d0 = done_total;
      xfer_start = 1'b1; xfer_abort = 1'b1;
      tick(1);
      xfer_start = 1'b0; xfer_abort = 1'b0;
      check("start_abort_busy", busy, 1'b1);
      check("start_abort_no_pulse", aborted, 1'b0);
      wait_idle(2000);
      check("start_abort_done", done_total - d0, 1);

      // Reset in SHIFT_HI is immediate and restores defaults.
      d0 = done_total; l0 = load_total;
      start_xfer(8'd3);
      tick(5);
      check("pre_rst_sclk_hi", serial_clock, 1'b1);
      #2 rstb = 1'b0;
      #1;
      check("async_rst_sclk", serial_clock, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_sload", serial_load, 1'b0);
      cfg_rd_addr = 6'd37;
      #1 check("rst_pad37", cfg_rd_data, 13'h0403);
      cfg_rd_addr = 6'd0;
      #1 check("rst_pad0", cfg_rd_data, 13'h0403);
      @(posedge clk);
      #1 rstb = 1'b1;
      tick(2);
      check("rst_no_done", done_total - d0, 0);
      check("rst_no_load", load_total - l0, 0);
      check("rst_idle_busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
